// File: rtl/mips_multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_controller_pkg
// Description : Shared state encodings, opcode constants, select codes and the
//               control-word type for the multicycle MIPS controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_multicycle_controller_pkg;

    // State encoding follows the listed order; S_RESET must be zero.
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

    // Control word produced by the output decoder; PCEn is formed from
    // pc_write/branch in the top because it also needs the ALU zero flag.
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW)   || (op == OP_SW)   || (op == OP_RTYPE) ||
               (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_controller_if
// Description : Controller <-> datapath/memory signal bundle. The controller
//               uses the master view, the datapath the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_controller_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       PCEn;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
               RegWrite, RegDst, MemtoReg, PCEn, illegal_op, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
               RegWrite, RegDst, MemtoReg, PCEn, illegal_op, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mips_mc_output_decode.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_output_decode
// Description : Combinational state-to-control-word decode. Fetch strobes are
//               gated by memory ready; illegal_op flags bad opcodes in decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_output_decode
    import mips_multicycle_controller_pkg::*;
(
    input  wire state_t     i_state,
    input  wire logic       i_mem_ready,
    input  wire logic [5:0] i_opcode,
    output ctrl_t           o_ctrl,
    output logic            o_illegal_op
);

    // Per-state control word; everything not named for a state stays zero.
    always_comb begin
        o_ctrl       = '0;
        o_illegal_op = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.iord      = 1'b0;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_src    = PCSRC_ALURESULT;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_illegal_op     = !is_legal_op(i_opcode);
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                // Write held for the whole access, including the ready cycle.
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
                o_ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_B;
                o_ctrl.alu_op    = ALUOP_SUB;
                o_ctrl.pc_src    = PCSRC_ALUOUT;
                o_ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b0;
                o_ctrl.reg_write  = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_src   = PCSRC_JUMP;
                o_ctrl.pc_write = 1'b1;
            end
            default: begin
                o_ctrl       = '0;
                o_illegal_op = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : mips_multicycle_controller
// Description : Main control FSM of the multicycle MIPS. Holds the state
//               register and next-state logic; control outputs come from
//               mips_mc_output_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_controller
    import mips_multicycle_controller_pkg::*;
#(
    parameter int MEM_WAIT_EN = 1
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    mips_multicycle_controller_if.master    bus
);

    state_t r_state;
    state_t w_next_state;
    logic   w_mem_ready;
    ctrl_t  w_ctrl;
    logic   w_illegal_op;

    // With waiting disabled, memory is assumed to complete every access.
    if (MEM_WAIT_EN != 0) begin : g_mem_wait
        assign w_mem_ready = bus.mem_ready;
    end else begin : g_no_mem_wait
        assign w_mem_ready = 1'b1;
    end

    // State register; reset aborts any instruction immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_RESET:   w_next_state = S_FETCH;
            S_FETCH:   w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_EXECUTE;
                    OP_BEQ:       w_next_state = S_BRANCH;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next_state = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next_state = S_FETCH;
            S_MEMWR:   w_next_state = w_mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ALUWB:   w_next_state = S_FETCH;
            S_BRANCH:  w_next_state = S_FETCH;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            S_ADDIWB:  w_next_state = S_FETCH;
            S_JUMP:    w_next_state = S_FETCH;
            default:   w_next_state = S_FETCH;
        endcase
    end

    mips_mc_output_decode u_output_decode (
        .i_state      (r_state),
        .i_mem_ready  (w_mem_ready),
        .i_opcode     (bus.opcode),
        .o_ctrl       (w_ctrl),
        .o_illegal_op (w_illegal_op)
    );

    assign bus.ALUOp      = w_ctrl.alu_op;
    assign bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign bus.PCSrc      = w_ctrl.pc_src;
    assign bus.IorD       = w_ctrl.iord;
    assign bus.IRWrite    = w_ctrl.ir_write;
    assign bus.MemWrite   = w_ctrl.mem_write;
    assign bus.RegWrite   = w_ctrl.reg_write;
    assign bus.RegDst     = w_ctrl.reg_dst;
    assign bus.MemtoReg   = w_ctrl.mem_to_reg;
    assign bus.PCEn       = w_ctrl.pc_write | (w_ctrl.branch & bus.zero);
    assign bus.illegal_op = w_illegal_op;
    assign bus.state_dbg  = r_state;

endmodule
`default_nettype wire
